// File: rtl/bm_loader.sv
// bm_loader: fetches WORDS consecutive memory words, one read outstanding at a time,
// and writes them to the register file as one bitmap image on a single strobe.
module bm_loader #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned BM_W   = 1536,
  parameter int unsigned WORDS  = 96,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [1:0]        dst_bm,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              wbm,
  output logic [1:0]        wbm_addr,
  output logic [BM_W-1:0]   wbm_data
);

  localparam int unsigned      IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [1:0]        dst_q,   dst_d;
  logic [BM_W-1:0]   buf_q,   buf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      dst_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
    end
  end

  // addr_q tracks base+idx directly, so the read address wraps naturally at 2^ADDR_W
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    dst_d   = dst_q;
    buf_d   = buf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          dst_d   = dst_bm;
          idx_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_valid) begin
          // new word enters at the top so word 0 ends at the LSBs after the last shift
          buf_d = {mem_rdata, buf_q[BM_W-1:WORD_W]};
          if (idx_q == LAST_IDX) begin
            state_d = S_WRITE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_REQ;
          end
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign mem_rd   = (state_q == S_REQ);
  assign wbm      = (state_q == S_WRITE);
  assign done     = (state_q == S_WRITE);
  assign mem_addr = addr_q;
  assign wbm_addr = dst_q;
  assign wbm_data = buf_q;

endmodule

// File: tb/tb_bm_loader.sv
// tb_bm_loader: directed loads against a data=address memory model; a scoreboard
// holds expected read addresses and bitmap writes, a monitor pops and compares them.
module tb_bm_loader;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BM_W   = 1536;
  localparam int unsigned WORDS  = 96;
  localparam int unsigned ADDR_W = 16;

  typedef struct {
    logic [1:0]      dst;
    logic [BM_W-1:0] img;
    int unsigned     scyc;
  } wexp_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [1:0]        dst_bm;
  logic              busy;
  logic              done;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              wbm;
  logic [1:0]        wbm_addr;
  logic [BM_W-1:0]   wbm_data;

  bm_loader #(.WORD_W(WORD_W), .BM_W(BM_W), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .dst_bm(dst_bm),
    .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .wbm(wbm), .wbm_addr(wbm_addr),
    .wbm_data(wbm_data)
  );

  int unsigned cyc = 0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [15:0] exp_addr[$];
  wexp_t       exp_w[$];
  int          rd_count = 0;
  int          wbm_count = 0;
  int          served = 0;
  int          lat_sum = 0;
  int          fixed_lat = 1;
  bit          rand_lat = 0;
  int          spur_word = -1;
  bit          outstanding = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_img(input string name, input logic [BM_W-1:0] act, input logic [BM_W-1:0] exp);
    int bad;
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else begin
      bad = -1;
      for (int k = WORDS - 1; k >= 0; k--)
        if (act[k*WORD_W +: WORD_W] !== exp[k*WORD_W +: WORD_W]) bad = k;
      if (bad >= 0)
        $display("FAIL %s: word %0d got 0x%h, expected 0x%h", name, bad,
                 act[bad*WORD_W +: WORD_W], exp[bad*WORD_W +: WORD_W]);
      else
        $display("FAIL %s: image differs in X/Z bits", name);
    end
  endtask

  function automatic logic [BM_W-1:0] img(input logic [15:0] base);
    logic [BM_W-1:0] r;
    r = '0;
    for (int k = 0; k < WORDS; k++) r[k*WORD_W +: WORD_W] = base + 16'(k);
    return r;
  endfunction

  task automatic push_exp(input logic [15:0] base, input logic [1:0] dst);
    wexp_t w;
    for (int k = 0; k < WORDS; k++) exp_addr.push_back(base + 16'(k));
    w.dst  = dst;
    w.img  = img(base);
    w.scyc = cyc;
    exp_w.push_back(w);
    lat_sum  = 0;
    served   = 0;
    rd_count = 0;
  endtask

  // start pulse in the current cycle; returns one cycle later
  task automatic do_load(input logic [15:0] base, input logic [1:0] dst);
    push_exp(base, dst);
    start     = 1'b1;
    base_addr = base;
    dst_bm    = dst;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_wbm(input int target, input int max_cyc);
    int n;
    n = 0;
    while (wbm_count < target && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("wbm_seen", 32'(wbm_count >= target), 32'd1);
    @(posedge clk); #1;
  endtask

  // memory model: data = address, returned after fixed or random latency
  initial begin
    int lat;
    logic [15:0] a;
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_rd && !rst) begin
        a   = mem_addr;
        lat = rand_lat ? int'($urandom_range(5, 1)) : fixed_lat;
        lat_sum += lat;
        if (served == spur_word) begin
          mem_valid = 1'b1;
          mem_rdata = 16'hDEAD;
        end
        served++;
        repeat (lat) @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_rdata = a;
        @(posedge clk); #1;
        mem_valid = 1'b0;
      end
    end
  end

  // monitor: pops expected reads and bitmap writes as the DUT presents them
  initial begin
    wexp_t w;
    forever begin
      @(negedge clk);
      if (rst) outstanding = 1'b0;
      else begin
        if (mem_valid) outstanding = 1'b0;
        if (mem_rd) begin
          rd_count++;
          chk("one_outstanding", 32'(outstanding), 32'd0);
          outstanding = 1'b1;
          if (exp_addr.size() == 0) chk("unexpected_rd", 32'd1, 32'd0);
          else chk("rd_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
        end
        if (wbm) begin
          wbm_count++;
          if (exp_w.size() == 0) chk("unexpected_wbm", 32'd1, 32'd0);
          else begin
            w = exp_w.pop_front();
            chk("wbm_addr", 32'(wbm_addr), 32'(w.dst));
            chk_img("wbm_image", wbm_data, w.img);
            chk("done_with_wbm", 32'(done), 32'd1);
            chk("wbm_cycle", cyc - w.scyc, 32'(1 + WORDS + lat_sum));
          end
        end
      end
    end
  end

  initial begin
    int wc;
    int n;
    rst = 1'b1; start = 1'b0; base_addr = '0; dst_bm = '0;

    // reset, with start asserted in the final reset cycle
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 16'h7777; dst_bm = 2'd1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_wbm", 32'(wbm), 32'd0);
    chk("rst_wbm_addr", 32'(wbm_addr), 32'd0);
    chk_img("rst_wbm_data", wbm_data, '0);
    @(posedge clk); #1;
    chk("start_in_reset_ignored", 32'(busy), 32'd0);

    // basic load with fixed one-cycle latency and exact timing
    do_load(16'h0100, 2'd1);
    chk("busy_cycle1", 32'(busy), 32'd1);
    chk("mem_rd_cycle1", 32'(mem_rd), 32'd1);
    repeat (192) @(posedge clk);
    #1;
    chk("done_cycle193", 32'(done), 32'd1);
    chk("wbm_cycle193", 32'(wbm), 32'd1);
    @(posedge clk); #1;
    chk("busy_cycle194", 32'(busy), 32'd0);
    chk("wbm_cycle194", 32'(wbm), 32'd0);
    chk("rd_count", 32'(rd_count), 32'(WORDS));
    chk("word0", 32'(wbm_data[15:0]), 32'h0100);
    chk("word95", 32'(wbm_data[1535:1520]), 32'h015F);
    repeat (5) @(posedge clk);
    #1;
    chk_img("image_held", wbm_data, img(16'h0100));

    // variable latency 1..5 per word
    rand_lat = 1'b1;
    wc = wbm_count;
    do_load(16'h0A00, 2'd0);
    wait_wbm(wc + 1, 1500);
    rand_lat = 1'b0;
    chk("rd_count_var", 32'(rd_count), 32'(WORDS));

    // address wrap past 0xFFFF
    wc = wbm_count;
    do_load(16'hFFF0, 2'd2);
    wait_wbm(wc + 1, 400);
    chk("wrap_word0", 32'(wbm_data[15:0]), 32'hFFF0);
    chk("wrap_word16", 32'(wbm_data[271:256]), 32'h0000);
    chk("wrap_word95", 32'(wbm_data[1535:1520]), 32'h004F);

    // start and spurious mem_valid during the REQ cycle of word 10
    wc = wbm_count;
    spur_word = 10;
    do_load(16'h4000, 2'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("req_word10", 32'(mem_rd), 32'd1);
    start = 1'b1; base_addr = 16'h1234; dst_bm = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_ignored_start", 32'(busy), 32'd1);
    wait_wbm(wc + 1, 400);
    spur_word = -1;
    repeat (10) @(posedge clk);
    #1;
    chk("single_wbm", 32'(wbm_count), 32'(wc + 1));
    chk("no_restart", 32'(busy), 32'd0);
    chk("dst_kept", 32'(wbm_addr), 32'd1);

    // reset in WAIT after word 40; the pending response returns in IDLE
    fixed_lat = 3;
    wc = wbm_count;
    do_load(16'h0800, 2'd3);
    n = 0;
    while (rd_count < 41 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_word40", 32'(rd_count >= 41), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_addr.delete();
    exp_w.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_mem_rd", 32'(mem_rd), 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    chk("abort_wbm", 32'(wbm), 32'd0);
    chk("abort_wbm_addr", 32'(wbm_addr), 32'd0);
    chk_img("abort_wbm_data", wbm_data, '0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_stays_idle", 32'(busy), 32'd0);
    chk("abort_no_wbm", 32'(wbm_count), 32'(wc));
    fixed_lat = 1;
    do_load(16'h0500, 2'd2);
    wait_wbm(wc + 1, 400);

    // back-to-back: start with done is ignored, start the next cycle is accepted
    wc = wbm_count;
    do_load(16'h2000, 2'd3);
    repeat (192) @(posedge clk);
    #1;
    chk("b2b_done", 32'(done), 32'd1);
    start = 1'b1; base_addr = 16'h6000; dst_bm = 2'd0;
    @(posedge clk); #1;
    chk("b2b_idle", 32'(busy), 32'd0);
    push_exp(16'h3000, 2'd2);
    start = 1'b1; base_addr = 16'h3000; dst_bm = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy_rise", 32'(busy), 32'd1);
    chk("b2b_mem_rd", 32'(mem_rd), 32'd1);
    wait_wbm(wc + 2, 400);

    repeat (4) @(posedge clk);
    #1;
    chk("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
    chk("wbm_queue_empty", 32'(exp_w.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/bm_loader.md
# bm_loader

Bitmap loader that fills one 1536-bit bitmap register in the CPU register file from 16-bit data memory. On a start pulse it fetches 96 consecutive 16-bit words beginning at a base address, one outstanding read at a time. It assembles the words into a 1536-bit image and issues a single write strobe on the register file's bitmap write port (`wbm`/`wbm_addr`/`wbm_data`). It sits between the data-memory read port and the register file, upstream of the bitmap registers, and is driven by the decode/execute stage when a bitmap-load instruction runs.

## Interface
- `WORD_W`, 16, memory word width
- `BM_W`, 1536, bitmap register width; must equal `WORDS*WORD_W`
- `WORDS`, 96, words per bitmap
- `ADDR_W`, 16, memory address width

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle load request, sampled only in IDLE
- `base_addr`  in  ADDR_W  first word address, latched on accepted start
- `dst_bm`  in  2  destination bitmap register index, latched on accepted start
- `busy`  out  1  high from the cycle after accepted start through the WRITE cycle
- `done`  out  1  one-cycle pulse, coincident with `wbm`
- `mem_rd`  out  1  one-cycle read request
- `mem_addr`  out  ADDR_W  read address, valid while `mem_rd`
- `mem_rdata`  in  WORD_W  read data, valid while `mem_valid`
- `mem_valid`  in  1  read data return, any latency ≥1 cycle after `mem_rd`
- `wbm`  out  1  bitmap write strobe, one cycle
- `wbm_addr`  out  2  latched `dst_bm`
- `wbm_data`  out  BM_W  assembled bitmap, driven continuously from the buffer

## Operation
- States: IDLE, REQ, WAIT, WRITE.
- IDLE: on `start`, latch `base_addr` and `dst_bm`, clear word index `idx` to 0, go to REQ. `mem_valid` is ignored here.
- REQ: `mem_rd`=1, `mem_addr`=`base_addr+idx` (mod 2^ADDR_W, wraps at 0xFFFF→0x0000), then go to WAIT. Held for exactly one cycle.
- WAIT: `mem_rd`=0. On `mem_valid`, shift the buffer right by WORD_W with `mem_rdata` entering at the MSBs. If `idx==WORDS-1`, go to WRITE; otherwise increment `idx` and go to REQ. Without `mem_valid`, stay in WAIT with no timeout.
- Word ordering: word k (address `base+k`) ends up at `wbm_data[16k+15:16k]`, so word 0 is at the LSBs.
- WRITE: `wbm`=1, `done`=1, `busy`=1 for one cycle, then go to IDLE.
- `start` while not IDLE is ignored; it is not queued.
- `mem_valid` in IDLE, REQ or WRITE is ignored; the buffer is unchanged.
- `dst_bm`=3 is passed through unmodified; the register file maps it to bitmap 0.
- `wbm_data` is not cleared after WRITE; it holds the last image until the next load overwrites it.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `mem_rd`=0, `mem_addr`=0, `wbm`=0, `wbm_addr`=0, `wbm_data`=0, `idx`=0.
- Reset has priority over every other event, including `start` in the same cycle.
- Reset mid-load aborts to IDLE with no `wbm` strobe. A later `mem_valid` for the aborted read is ignored.
- With `start` in cycle 0 and `mem_valid` always one cycle after `mem_rd`:
  - `mem_rd` is high in cycles 1, 3, …, 191.
  - Data is captured in cycles 2, 4, …, 192.
  - WRITE, `wbm`, and `done` fall in cycle 193.
  - `busy` is high in cycles 1–193.
- A new `start` is accepted in cycle 194 at the earliest.
- Minimum load time is 2·WORDS+1 cycles. Every extra cycle of memory latency adds one cycle per word.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then one load: `base_addr`=0x0100, `dst_bm`=1, memory returns data=address one cycle later. Required: 96 reads at 0x0100–0x015F; `wbm`/`done` in cycle 193; `wbm_addr`=1; `wbm_data[15:0]`=0x0100 and `wbm_data[1535:1520]`=0x015F.
- Variable latency: `mem_valid` delayed randomly 1–5 cycles per word. Required: only one `mem_rd` outstanding at a time, correct image, and total cycles equal 1 + 96 + Σlatency.
- Address wrap: `base_addr`=0xFFF0. Required: reads at 0xFFF0–0xFFFF then 0x0000–0x004F; word 16 lands at bits [271:256].
- Ignored events: pulse `start` (with `dst_bm`=2) and a spurious `mem_valid` during a REQ cycle of a running load. Required: no restart, original `dst_bm` kept, image unchanged, exactly one `wbm` pulse.
- Reset mid-load: assert `rst` in the WAIT state after word 40, then return the pending `mem_valid`. Required: next cycle has IDLE outputs all 0, no `wbm`; the following load completes normally.
- Back-to-back: assert `start` in the same cycle as `done`, then again in the next cycle. Required: the first is ignored, the second is accepted, and `busy` rises one cycle later.
